// File: rtl/zoom_pkg.sv
// Shared FSM encoding and zoom-mode constants for the nearest-neighbour zoom scanner.
package zoom_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_OUT = 1'b0;  // decimate: src = dst << shift
  localparam logic MODE_IN  = 1'b1;  // replicate: src = dst >> shift

endpackage

// File: rtl/zoom_map.sv
// One-axis coordinate map: power-of-two scale, pan offset, range check, saturation.
module zoom_map
  import zoom_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int LIMIT   = 640
) (
  input  logic [COORD_W-1:0] dst,
  input  logic               mode,
  input  logic [1:0]         shift,
  input  logic [COORD_W-1:0] pan,
  output logic [COORD_W-1:0] src,
  output logic               oob
);

  localparam int IW = COORD_W + 3;  // holds dst << 3 without loss
  localparam int SW = COORD_W + 4;  // one more bit so adding pan cannot wrap

  logic [IW-1:0] scaled;
  logic [SW-1:0] sum;

  always_comb begin
    scaled = (mode == MODE_IN) ? (IW'(dst) >> shift) : (IW'(dst) << shift);
    sum    = SW'(scaled) + SW'(pan);
    oob    = (sum >= SW'(LIMIT));
    // In range means sum < LIMIT <= 2^COORD_W, so the low bits are the full value.
    src    = oob ? COORD_W'(LIMIT - 1) : sum[COORD_W-1:0];
  end

endmodule

// File: rtl/zoom_nni_scan.sv
// Destination raster scanner producing nearest-neighbour source coordinates per beat.
// Optional pan offset (pan_x/pan_y ports) is enabled by defining ZOOM_PAN_EN.
module zoom_nni_scan
  import zoom_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int SRC_W   = 640,
  parameter int SRC_H   = 480,
  parameter int DST_W   = 640,
  parameter int DST_H   = 480,
  parameter int ADDR_W  = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [1:0]         shift,
`ifdef ZOOM_PAN_EN
  input  logic [COORD_W-1:0] pan_x,
  input  logic [COORD_W-1:0] pan_y,
`endif
  input  logic               out_ready,
  output logic               out_valid,
  output logic [COORD_W-1:0] x_dst,
  output logic [COORD_W-1:0] y_dst,
  output logic [COORD_W-1:0] x_src,
  output logic [COORD_W-1:0] y_src,
  output logic [ADDR_W-1:0]  src_addr,
  output logic               oob,
  output logic               last,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic               mode_q;
  logic [1:0]         shift_q;
  logic [COORD_W-1:0] pan_x_q, pan_y_q;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic               x_end, at_last, fire;
  logic               oob_x, oob_y;

  assign x_end   = (x_cnt == COORD_W'(DST_W - 1));
  assign at_last = x_end && (y_cnt == COORD_W'(DST_H - 1));
  assign fire    = out_valid && out_ready;

`ifndef ZOOM_PAN_EN
  assign pan_x_q = '0;
  assign pan_y_q = '0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= MODE_OUT;
      shift_q   <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ZOOM_PAN_EN
      pan_x_q   <= '0;
      pan_y_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            mode_q    <= mode;
            shift_q   <= shift;
            x_cnt     <= '0;
            y_cnt     <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
`ifdef ZOOM_PAN_EN
            pan_x_q   <= pan_x;
            pan_y_q   <= pan_y;
`endif
          end
        end
        RUN: begin
          if (fire) begin
            if (at_last) begin
              state     <= DONE;
              x_cnt     <= '0;
              y_cnt     <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else if (x_end) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + 1'b1;
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat outputs depend only on registers, never on out_ready.
  assign x_dst = x_cnt;
  assign y_dst = y_cnt;
  assign last  = (state == RUN) && at_last;
  assign oob   = oob_x || oob_y;

  zoom_map #(.COORD_W(COORD_W), .LIMIT(SRC_W)) u_map_x (
    .dst(x_cnt), .mode(mode_q), .shift(shift_q), .pan(pan_x_q), .src(x_src), .oob(oob_x)
  );

  zoom_map #(.COORD_W(COORD_W), .LIMIT(SRC_H)) u_map_y (
    .dst(y_cnt), .mode(mode_q), .shift(shift_q), .pan(pan_y_q), .src(y_src), .oob(oob_y)
  );

  assign src_addr = ADDR_W'(y_src) * ADDR_W'(SRC_W) + ADDR_W'(x_src);

endmodule

// File: tb/tb_zoom_nni_scan.sv
// Directed bench for zoom_nni_scan; DST_H is reduced to 12 lines to keep full frames short.
module tb_zoom_nni_scan;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 19;

  logic               clk = 1'b0;
  logic               reset, start, mode, out_ready;
  logic [1:0]         shift;
  logic [COORD_W-1:0] pan_x, pan_y;
  logic               out_valid, oob, last, busy, done;
  logic [COORD_W-1:0] x_dst, y_dst, x_src, y_src;
  logic [ADDR_W-1:0]  src_addr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  zoom_nni_scan #(
    .COORD_W(COORD_W), .SRC_W(640), .SRC_H(480), .DST_W(640), .DST_H(12), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .shift(shift),
`ifdef ZOOM_PAN_EN
    .pan_x(pan_x), .pan_y(pan_y),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .x_dst(x_dst), .y_dst(y_dst),
    .x_src(x_src), .y_src(y_src), .src_addr(src_addr), .oob(oob), .last(last),
    .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    out_ready = 1'b0;
    start     = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_frame(input logic m, input logic [1:0] s);
    mode  = m;
    shift = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Handshake n beats back to back, then hold off the consumer.
  task automatic advance(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mode = 1'b1; shift = 2'd3; out_ready = 1'b1;
    repeat (3) tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else passed++;
    total++; if ({done, last, oob} !== 3'b000) $display("FAIL rst_flags got %b want 000", {done, last, oob}); else passed++;
    total++; if ({x_dst, y_dst, x_src, y_src} !== '0) $display("FAIL rst_coords got %h want 0", {x_dst, y_dst, x_src, y_src}); else passed++;
    total++; if (src_addr !== '0) $display("FAIL rst_addr got %0d want 0", src_addr); else passed++;
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    tick();
  endtask

  task automatic test_zoom_out();
    start_frame(1'b0, 2'd1);
    total++; if ({out_valid, busy} !== 2'b11) $display("FAIL zo_first_vb got %b want 11", {out_valid, busy}); else passed++;
    total++; if ({x_dst, y_dst} !== '0) $display("FAIL zo_first_xy got (%0d,%0d) want (0,0)", x_dst, y_dst); else passed++;
    advance(5 * 640 + 10);
    total++; if ({x_dst, y_dst} !== {10'd10, 10'd5}) $display("FAIL zo_dst got (%0d,%0d) want (10,5)", x_dst, y_dst); else passed++;
    total++; if ({x_src, y_src} !== {10'd20, 10'd10}) $display("FAIL zo_src got (%0d,%0d) want (20,10)", x_src, y_src); else passed++;
    total++; if (src_addr !== 19'd6420) $display("FAIL zo_addr got %0d want 6420", src_addr); else passed++;
    total++; if (oob !== 1'b0) $display("FAIL zo_oob got %0b want 0", oob); else passed++;
    // Config inputs and start toggled mid-run must be ignored.
    mode = 1'b1; shift = 2'd3; start = 1'b1;
    advance(1);
    start = 1'b0;
    total++; if ({x_dst, y_dst} !== {10'd11, 10'd5}) $display("FAIL zo_norestart got (%0d,%0d) want (11,5)", x_dst, y_dst); else passed++;
    total++; if ({x_src, src_addr} !== {10'd22, 19'd6422}) $display("FAIL zo_latched got x_src %0d addr %0d want 22 6422", x_src, src_addr); else passed++;
    do_reset();
  endtask

  task automatic test_oob();
    start_frame(1'b0, 2'd1);
    advance(319);
    total++; if ({oob, x_src} !== {1'b0, 10'd638}) $display("FAIL oob_319 got oob %0b x_src %0d want 0 638", oob, x_src); else passed++;
    advance(1);
    total++; if ({oob, x_src} !== {1'b1, 10'd639}) $display("FAIL oob_320 got oob %0b x_src %0d want 1 639", oob, x_src); else passed++;
    advance(80);
    total++; if ({x_dst, oob, x_src, y_src} !== {10'd400, 1'b1, 10'd639, 10'd0}) $display("FAIL oob_400 got x_dst %0d oob %0b src (%0d,%0d) want 400 1 (639,0)", x_dst, oob, x_src, y_src); else passed++;
    total++; if (src_addr !== 19'd639) $display("FAIL oob_addr got %0d want 639", src_addr); else passed++;
    do_reset();
  endtask

  task automatic test_identity();
    start_frame(1'b0, 2'd0);
    advance(3 * 640 + 5);
    total++; if ({x_src, y_src} !== {10'd5, 10'd3}) $display("FAIL id_out got (%0d,%0d) want (5,3)", x_src, y_src); else passed++;
    do_reset();
    start_frame(1'b1, 2'd0);
    advance(2 * 640 + 600);
    total++; if ({x_src, y_src, src_addr} !== {10'd600, 10'd2, 19'd1880}) $display("FAIL id_in got (%0d,%0d) addr %0d want (600,2) 1880", x_src, y_src, src_addr); else passed++;
    do_reset();
  endtask

  task automatic test_full_frame();
    start_frame(1'b1, 2'd2);
    advance(9 * 640 + 7);
    total++; if ({x_src, y_src} !== {10'd1, 10'd2}) $display("FAIL ff_src got (%0d,%0d) want (1,2)", x_src, y_src); else passed++;
    total++; if ({src_addr, oob, last} !== {19'd1281, 1'b0, 1'b0}) $display("FAIL ff_addr got %0d oob %0b last %0b want 1281 0 0", src_addr, oob, last); else passed++;
    advance(10 * 640 + 639 - (9 * 640 + 7));
    total++; if ({x_dst, y_dst, last} !== {10'd639, 10'd10, 1'b0}) $display("FAIL ff_rowend got (%0d,%0d) last %0b want (639,10) 0", x_dst, y_dst, last); else passed++;
    advance(640);
    total++; if ({x_dst, y_dst, last, out_valid} !== {10'd639, 10'd11, 1'b1, 1'b1}) $display("FAIL ff_last got (%0d,%0d) last %0b valid %0b want (639,11) 1 1", x_dst, y_dst, last, out_valid); else passed++;
    total++; if ({x_src, y_src, done} !== {10'd159, 10'd2, 1'b0}) $display("FAIL ff_lastsrc got (%0d,%0d) done %0b want (159,2) 0", x_src, y_src, done); else passed++;
    advance(1);
    total++; if ({done, busy, out_valid, last} !== 4'b1100) $display("FAIL ff_done got d/b/v/l %b want 1100", {done, busy, out_valid, last}); else passed++;
    tick();
    total++; if ({done, busy} !== 2'b00) $display("FAIL ff_idle got d/b %b want 00", {done, busy}); else passed++;
  endtask

  task automatic test_stall();
    start_frame(1'b0, 2'd0);
    advance(100);
    for (int i = 0; i < 5; i++) begin
      total++; if ({out_valid, x_dst, x_src, y_dst} !== {1'b1, 10'd100, 10'd100, 10'd0}) $display("FAIL stall_hold%0d got v %0b x_dst %0d x_src %0d", i, out_valid, x_dst, x_src); else passed++;
      tick();
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++; if (x_dst !== COORD_W'(100 + i)) $display("FAIL stall_seq%0d got %0d want %0d", i, x_dst, 100 + i); else passed++;
    end
    out_ready = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    start_frame(1'b0, 2'd0);
    advance(1000);
    total++; if ({x_dst, y_dst} !== {10'd360, 10'd1}) $display("FAIL rm_pos got (%0d,%0d) want (360,1)", x_dst, y_dst); else passed++;
    reset = 1'b1;
    tick();
    saw_done = done;
    reset = 1'b0;
    total++; if ({busy, out_valid, x_dst, y_dst} !== '0) $display("FAIL rm_abort got busy %0b valid %0b (%0d,%0d)", busy, out_valid, x_dst, y_dst); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      saw_done = saw_done | done;
    end
    total++; if (saw_done !== 1'b0) $display("FAIL rm_nodone got %0b want 0", saw_done); else passed++;
    start_frame(1'b0, 2'd0);
    total++; if ({out_valid, x_dst, y_dst} !== {1'b1, 20'd0}) $display("FAIL rm_restart got v %0b (%0d,%0d) want 1 (0,0)", out_valid, x_dst, y_dst); else passed++;
    do_reset();
  endtask

`ifdef ZOOM_PAN_EN
  task automatic test_pan();
    pan_x = 10'd100; pan_y = 10'd50;
    start_frame(1'b1, 2'd0);
    pan_x = 10'd0; pan_y = 10'd0;
    total++; if ({x_src, y_src} !== {10'd100, 10'd50}) $display("FAIL pan_src got (%0d,%0d) want (100,50)", x_src, y_src); else passed++;
    total++; if ({src_addr, oob} !== {19'd32100, 1'b0}) $display("FAIL pan_addr got %0d oob %0b want 32100 0", src_addr, oob); else passed++;
    advance(540);
    total++; if ({oob, x_src} !== {1'b1, 10'd639}) $display("FAIL pan_oob got oob %0b x_src %0d want 1 639", oob, x_src); else passed++;
    do_reset();
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; shift = 2'd0; out_ready = 1'b0;
    pan_x = '0; pan_y = '0;
    test_reset();
    test_zoom_out();
    test_oob();
    test_identity();
    test_full_frame();
    test_stall();
    test_reset_mid();
`ifdef ZOOM_PAN_EN
    test_pan();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/zoom_nni_scan.md
ZOOM_NNI_SCAN -- requirements
Module: zoom_nni_scan

Interface
REQ-001 SHALL have parameter COORD_W, default 10: coordinate width in bits.
REQ-002 SHALL have parameter SRC_W, default 640: source image width in pixels.
REQ-003 SHALL have parameter SRC_H, default 480: source image height in pixels.
REQ-004 SHALL have parameter DST_W, default 640: destination raster width.
REQ-005 SHALL have parameter DST_H, default 480: destination raster height.
REQ-006 SHALL have parameter ADDR_W, default 19: source linear address width.
REQ-007 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-008 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port start, input, 1 bit: begin one frame scan.
REQ-010 SHALL have port mode, input, 1 bit: 0 = zoom-out (decimate), 1 = zoom-in (replicate).
REQ-011 SHALL have port shift, input, 2 bits: zoom factor 2^shift (1x, 2x, 4x, 8x).
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the current beat.
REQ-013 SHALL have port out_valid, output, 1 bit: the beat is valid.
REQ-014 SHALL have ports x_dst and y_dst, output, COORD_W bits each: destination coordinate.
REQ-015 SHALL have ports x_src and y_src, output, COORD_W bits each: mapped source coordinate.
REQ-016 SHALL have port src_addr, output, ADDR_W bits: y_src*SRC_W + x_src.
REQ-017 SHALL have port oob, output, 1 bit: the mapped source lies outside the image.
REQ-018 SHALL have port last, output, 1 bit: the beat is the final pixel of the frame.
REQ-019 SHALL have port busy, output, 1 bit: a scan is in progress.
REQ-020 SHALL have port done, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE -> RUN on start.
- RUN -> DONE on handshake of the last beat.
- DONE -> IDLE after exactly one cycle.
REQ-022 SHALL latch mode and shift on the start cycle; changes to these inputs during RUN SHALL have no effect.
REQ-023 SHALL ignore start in RUN and DONE.
REQ-024 SHALL assert out_valid from the first cycle after start, with x_dst=0 and y_dst=0.
REQ-025 SHALL advance the raster only on out_valid && out_ready.
- x_dst increments.
- At DST_W-1, x_dst wraps to 0 and y_dst increments.
REQ-026 SHALL hold all beat outputs stable while out_valid && !out_ready.
REQ-027 SHALL map coordinates as follows:
- Zoom-out: src = dst << shift.
- Zoom-in: src = dst >> shift.
- Intermediate width: COORD_W+3 bits, no truncation before the range check.
REQ-028 SHALL, when intermediate x >= SRC_W or y >= SRC_H, assert oob and saturate the offending coordinate to SRC_W-1 or SRC_H-1.
REQ-029 SHALL compute src_addr from the saturated coordinates.
REQ-030 SHALL derive all beat outputs from registered state, so beat outputs have no combinational path from out_ready.
REQ-031 SHALL assert last only when x_dst=DST_W-1 and y_dst=DST_H-1.
REQ-032 SHALL assert busy in RUN and DONE.
REQ-033 SHALL assert done only in DONE.
REQ-034 SHALL treat shift=0 as identity in both modes.

Reset
REQ-035 SHALL apply reset synchronously, overriding every other input.
- FSM -> IDLE.
- Counters -> 0.
- out_valid, oob, last, busy, done -> 0.
- x_dst, y_dst, x_src, y_src, src_addr -> 0.
REQ-036 SHALL, on reset asserted mid-RUN, abort the frame without pulsing done; the next start SHALL rescan from (0,0).

Configuration
REQ-037 SHALL add pan support when macro ZOOM_PAN_EN is defined:
- Input ports pan_x and pan_y, COORD_W bits each, latched on start.
- Pan is added to the mapped intermediate coordinate before the REQ-028 range check.
REQ-038 SHALL, without ZOOM_PAN_EN, have no pan ports and an effective pan of 0.

Structure
REQ-039 SHALL take the FSM state encoding and MODE_OUT/MODE_IN constants from shared package zoom_pkg.
REQ-040 SHALL place the shift, pan, range-check and saturation datapath in one combinational sub-module, zoom_map, instantiated once per axis.

Verification
REQ-041 SHALL cover: mode=0, shift=1, out_ready=1, start -> beat (10,5) gives src (20,10), src_addr=6420, oob=0.
REQ-042 SHALL cover: mode=0, shift=1, dst (400,0) -> intermediate x 800 >= 640, so oob=1, x_src=639.
REQ-043 SHALL cover: mode=1, shift=2, dst (7,9) -> src (1,2); full frame of 307200 beats, last on the final beat, done one cycle later.
REQ-044 SHALL cover: out_ready low for 5 cycles mid-frame -> outputs stable and no coordinate skipped or duplicated.
REQ-045 SHALL cover: reset at beat 1000, then start -> first beat (0,0), and no done pulse from the aborted frame.
REQ-046 SHALL cover: with ZOOM_PAN_EN, pan=(100,50), mode=1, shift=0, dst (0,0) -> src (100,50), src_addr=32100.
